// File: rtl/grid_clb_param_if.sv
// Bus interface for the grid_clb_param logic tile.
// Groups the configuration, scan, cascade and LUT input/output signals.
// clk and reset stay as plain ports on the tile.
//   master : drives Test_en, config_en, ccff_head, clb_I, clb_reg_in, clb_sc_in;
//            observes clb_O, clb_reg_out, clb_sc_out, ccff_tail, cfg_done
//   slave  : the tile itself (opposite directions)
interface grid_clb_param_if #(
   parameter int NUM_BLE = 8,
   parameter int LUT_K   = 4
);
   logic                       Test_en;
   logic                       config_en;
   logic                       ccff_head;
   logic [NUM_BLE*LUT_K-1:0]   clb_I;
   logic                       clb_reg_in;
   logic                       clb_sc_in;
   logic [NUM_BLE-1:0]         clb_O;
   logic                       clb_reg_out;
   logic                       clb_sc_out;
   logic                       ccff_tail;
   logic                       cfg_done;

   modport master (
      output Test_en, config_en, ccff_head, clb_I, clb_reg_in, clb_sc_in,
      input  clb_O, clb_reg_out, clb_sc_out, ccff_tail, cfg_done
   );

   modport slave (
      input  Test_en, config_en, ccff_head, clb_I, clb_reg_in, clb_sc_in,
      output clb_O, clb_reg_out, clb_sc_out, ccff_tail, cfg_done
   );
endinterface

// File: rtl/grid_clb_param.sv
// Parametrised CLB tile: NUM_BLE basic logic elements, each a LUT_K-input LUT
// plus one user flip-flop, configured through an internal serial chain.
// Ports:
//   clk    : single clock for the config chain and user FFs
//   reset  : synchronous, active-high; clears config, FFs and the config counter
//   bus    : grid_clb_param_if slave modport
//            Test_en     scan mode, user FFs form a shift chain
//            config_en   shift the config chain one bit per cycle
//            ccff_head   config serial in; ccff_tail config serial out (MSB)
//            clb_I       LUT inputs, BLE i uses clb_I[i*LUT_K +: LUT_K]
//            clb_reg_in  cascade input into BLE0; clb_reg_out = q of last BLE
//            clb_sc_in   scan input into BLE0;    clb_sc_out  = q of last BLE
//            clb_O       per-BLE output (registered or combinational)
//            cfg_done    a full CFG_BITS bits shifted in this config session
// Per-BLE config field cfg[i*W +: W]: LUT mask, then ff_en, then reg_sel.
module grid_clb_param #(
   parameter int NUM_BLE = 8,
   parameter int LUT_K   = 4
) (
   input  logic             clk,
   input  logic             reset,
   grid_clb_param_if.slave  bus
);
   localparam int MASK_W   = 2**LUT_K;
   localparam int W        = MASK_W + 2;
   localparam int CFG_BITS = NUM_BLE * W;
   localparam int CW       = $clog2(CFG_BITS + 1);

   logic [CFG_BITS-1:0] cfg_reg;
   logic [NUM_BLE-1:0]  q_reg;
   logic [NUM_BLE-1:0]  q_next;
   logic [NUM_BLE-1:0]  lut_out;
   logic [NUM_BLE-1:0]  ff_en;
   logic [NUM_BLE-1:0]  reg_sel;
   logic [NUM_BLE-1:0]  chain_in;
   logic [NUM_BLE-1:0]  clb_o;
   logic [CW-1:0]       count_reg;
   logic [CW-1:0]       count_next;
   logic                cfg_en_d_reg;
   logic                cfg_done_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BLE; gi++) begin : g_ble
         logic [MASK_W-1:0] mask;
         logic [LUT_K-1:0]  sel;

         assign mask         = cfg_reg[gi*W +: MASK_W];
         assign ff_en[gi]    = cfg_reg[gi*W + MASK_W];
         assign reg_sel[gi]  = cfg_reg[gi*W + MASK_W + 1];
         assign sel          = bus.clb_I[gi*LUT_K +: LUT_K];
         assign lut_out[gi]  = mask[sel];

         // Scan and cascade share the same FF-to-FF path; they differ only in
         // which external bit enters BLE0.
         if (gi == 0) begin : g_head
            assign chain_in[gi] = bus.Test_en ? bus.clb_sc_in : bus.clb_reg_in;
         end else begin : g_link
            assign chain_in[gi] = q_reg[gi-1];
         end

         // Config shifting freezes user state; scan outranks the cascade select.
         assign q_next[gi] = bus.config_en ? q_reg[gi] :
                             (bus.Test_en || reg_sel[gi]) ? chain_in[gi] : lut_out[gi];

         // Outputs are forced low while the configuration is in flux.
         assign clb_o[gi] = bus.config_en ? 1'b0 : (ff_en[gi] ? q_reg[gi] : lut_out[gi]);
      end
   endgenerate

   // A new config session starts on the rising edge of config_en; the count
   // saturates so over-shifting keeps cfg_done asserted.
   always_comb begin
      count_next = count_reg;
      if (bus.config_en) begin
         if (!cfg_en_d_reg) begin
            count_next = CW'(1);
         end else if (count_reg != CW'(CFG_BITS)) begin
            count_next = count_reg + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_reg      <= '0;
         q_reg        <= '0;
         count_reg    <= '0;
         cfg_en_d_reg <= 1'b0;
         cfg_done_reg <= 1'b0;
      end else begin
         if (bus.config_en) begin
            cfg_reg <= {cfg_reg[CFG_BITS-2:0], bus.ccff_head};
         end
         q_reg        <= q_next;
         count_reg    <= count_next;
         cfg_en_d_reg <= bus.config_en;
         cfg_done_reg <= (count_next == CW'(CFG_BITS));
      end
   end

   assign bus.clb_O       = clb_o;
   assign bus.clb_reg_out = q_reg[NUM_BLE-1];
   assign bus.clb_sc_out  = q_reg[NUM_BLE-1];
   assign bus.ccff_tail   = cfg_reg[CFG_BITS-1];
   assign bus.cfg_done    = cfg_done_reg;
endmodule

// File: tb/tb_grid_clb_param.sv
// Directed bench for grid_clb_param with NUM_BLE=2, LUT_K=2 (W=6, CFG_BITS=12).
// Config word layout: {reg_sel1, ff_en1, mask1[3:0], reg_sel0, ff_en0, mask0[3:0]},
// loaded MSB first so the word lands in cfg unchanged.
module tb_grid_clb_param;
   localparam int NB = 2;
   localparam int LK = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   grid_clb_param_if #(.NUM_BLE(NB), .LUT_K(LK)) bus ();
   grid_clb_param #(.NUM_BLE(NB), .LUT_K(LK)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] cfg;
      logic [3:0]  clb_i;
      logic [1:0]  exp_o;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] mk(input logic [3:0] m0, input logic f0, input logic r0,
                                      input logic [3:0] m1, input logic f1, input logic r1);
      return {r1, f1, m1, r0, f0, m0};
   endfunction

   task automatic load_cfg(input logic [11:0] v);
      bus.config_en = 1'b1;
      for (int i = 11; i >= 0; i--) begin
         bus.ccff_head = v[i];
         tick();
      end
      bus.config_en = 1'b0;
      bus.ccff_head = 1'b0;
   endtask

   initial begin
      logic [11:0] cfg_and_xor;
      logic [11:0] cfg_xor_or;
      logic [11:0] cfg_nor;
      logic [11:0] pat;

      bus.Test_en    = 1'b0;
      bus.config_en  = 1'b0;
      bus.ccff_head  = 1'b0;
      bus.clb_I      = '0;
      bus.clb_reg_in = 1'b0;
      bus.clb_sc_in  = 1'b0;

      cfg_and_xor = mk(4'b1000, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0);
      cfg_xor_or  = mk(4'b0110, 1'b1, 1'b0, 4'b1110, 1'b0, 1'b0);
      cfg_nor     = mk(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0);

      // Expected outputs after one edge: LUT value for both ff_en settings.
      vecs[0] = '{cfg_and_xor, 4'b0111, 2'b11};
      vecs[1] = '{cfg_and_xor, 4'b0011, 2'b01};
      vecs[2] = '{cfg_and_xor, 4'b1011, 2'b11};
      vecs[3] = '{cfg_and_xor, 4'b1110, 2'b00};
      vecs[4] = '{cfg_xor_or,  4'b0000, 2'b00};
      vecs[5] = '{cfg_xor_or,  4'b0001, 2'b01};
      vecs[6] = '{cfg_xor_or,  4'b0100, 2'b10};
      vecs[7] = '{cfg_xor_or,  4'b1111, 2'b10};
      vecs[8] = '{cfg_nor,     4'b0000, 2'b11};
      vecs[9] = '{cfg_nor,     4'b0101, 2'b00};

      // Reset state
      tick();
      chk("reset_clb_o",    16'(bus.clb_O), 16'h0);
      chk("reset_reg_out",  16'(bus.clb_reg_out), 16'h0);
      chk("reset_sc_out",   16'(bus.clb_sc_out), 16'h0);
      chk("reset_tail",     16'(bus.ccff_tail), 16'h0);
      chk("reset_cfg_done", 16'(bus.cfg_done), 16'h0);
      reset = 1'b0;

      // Reset mid-stream: five ones shifted, then reset wipes them
      bus.config_en = 1'b1;
      bus.ccff_head = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.config_en = 1'b0;
      bus.ccff_head = 1'b0;
      tick();
      chk("midreset_tail", 16'(bus.ccff_tail), 16'h0);
      chk("midreset_done", 16'(bus.cfg_done), 16'h0);
      chk("midreset_clb_o", 16'(bus.clb_O), 16'h0);

      // Full reload: cfg_done rises only on the 12th shift; tail shows first bit
      pat = 12'hA5C;
      bus.config_en = 1'b1;
      for (int i = 11; i >= 0; i--) begin
         bus.ccff_head = pat[i];
         tick();
         if (i == 1) chk("done_after_11", 16'(bus.cfg_done), 16'h0);
      end
      chk("done_after_12", 16'(bus.cfg_done), 16'h1);
      chk("tail_first_bit", 16'(bus.ccff_tail), 16'(pat[11]));
      chk("clb_o_gated_cfg", 16'(bus.clb_O), 16'h0);
      bus.ccff_head = 1'b1;
      tick();
      chk("tail_second_bit", 16'(bus.ccff_tail), 16'(pat[10]));
      chk("done_after_13", 16'(bus.cfg_done), 16'h1);
      bus.config_en = 1'b0;
      tick();
      chk("done_hold_idle", 16'(bus.cfg_done), 16'h1);

      // New session restarts the count
      bus.config_en = 1'b1;
      for (int i = 11; i >= 0; i--) begin
         bus.ccff_head = cfg_and_xor[i];
         tick();
         if (i == 11) chk("resession_done_1", 16'(bus.cfg_done), 16'h0);
         if (i == 1)  chk("resession_done_11", 16'(bus.cfg_done), 16'h0);
      end
      chk("resession_done_12", 16'(bus.cfg_done), 16'h1);
      bus.config_en = 1'b0;
      bus.ccff_head = 1'b0;

      // Table-driven LUT vectors
      for (int k = 0; k < 10; k++) begin
         if (k == 0 || vecs[k].cfg != vecs[k-1].cfg) load_cfg(vecs[k].cfg);
         bus.clb_I = vecs[k].clb_i;
         tick();
         $display("vec %0d cfg=%03h clb_I=%b clb_O=%b", k, vecs[k].cfg, vecs[k].clb_i, bus.clb_O);
         chk($sformatf("vec%0d_clb_o", k), 16'(bus.clb_O), 16'(vecs[k].exp_o));
      end

      // Latency: BLE0 combinational (0 cycles), BLE1 registered (1 cycle)
      load_cfg(cfg_and_xor);
      bus.clb_I = 4'b1110;
      tick();
      bus.clb_I = 4'b0111;
      #1;
      chk("lat_ble0_same_cycle", 16'(bus.clb_O[0]), 16'h1);
      chk("lat_ble1_same_cycle", 16'(bus.clb_O[1]), 16'h0);
      tick();
      chk("lat_ble1_next_cycle", 16'(bus.clb_O[1]), 16'h1);

      // Cascade: reg_in -> reg_out delayed two cycles
      load_cfg(mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1));
      bus.clb_reg_in = 1'b1;
      tick();
      bus.clb_reg_in = 1'b0;
      tick();
      chk("cascade_out_1", 16'(bus.clb_reg_out), 16'h1);
      bus.clb_reg_in = 1'b1;
      tick();
      chk("cascade_out_0", 16'(bus.clb_reg_out), 16'h0);
      chk("cascade_clb_o1", 16'(bus.clb_O[1]), 16'h0);
      tick();
      chk("cascade_out_2", 16'(bus.clb_reg_out), 16'h1);
      bus.clb_reg_in = 1'b0;

      // Scan: independent of ff_en/reg_sel
      load_cfg(cfg_nor);
      bus.Test_en   = 1'b1;
      bus.clb_sc_in = 1'b0;
      tick();
      tick();
      chk("scan_flush", 16'(bus.clb_sc_out), 16'h0);
      bus.clb_sc_in = 1'b1;
      tick();
      tick();
      chk("scan_out_1a", 16'(bus.clb_sc_out), 16'h1);
      bus.clb_sc_in = 1'b0;
      tick();
      chk("scan_out_1b", 16'(bus.clb_sc_out), 16'h1);
      tick();
      chk("scan_out_0", 16'(bus.clb_sc_out), 16'h0);
      chk("scan_reg_out_tap", 16'(bus.clb_reg_out), 16'h0);

      // Scan with config_en: FFs hold and outputs gated
      bus.clb_sc_in = 1'b1;
      tick();
      tick();
      bus.clb_sc_in = 1'b0;
      bus.config_en = 1'b1;
      tick();
      tick();
      chk("scan_hold_out", 16'(bus.clb_sc_out), 16'h1);
      chk("scan_hold_clb_o", 16'(bus.clb_O), 16'h0);
      bus.config_en = 1'b0;
      tick();
      chk("scan_resume_held", 16'(bus.clb_sc_out), 16'h1);
      tick();
      chk("scan_resume_shift", 16'(bus.clb_sc_out), 16'h0);
      bus.Test_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
